// File: rtl/cp0_intc_pkg.sv
// rtl/cp0_intc_pkg.sv - shared CP0 register numbers and Status/Cause bit positions
//
// Purpose: constants shared by the CP0 interrupt controller and its users.
//   STATUS_REG/CAUSE_REG/EPC_REG : CP0 register numbers (rd field of MFC0/MTC0)
//   IE_BIT/EXL_BIT/IM_LSB        : Status bit positions
//   IP_LSB                       : Cause bit position of the first pending line
package cp0_intc_pkg;

  localparam logic [4:0] STATUS_REG = 5'd12;
  localparam logic [4:0] CAUSE_REG  = 5'd13;
  localparam logic [4:0] EPC_REG    = 5'd14;

  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int IM_LSB  = 8;
  localparam int IP_LSB  = 8;

endpackage

// File: rtl/cp0_intc.sv
// rtl/cp0_intc.sv - coprocessor-0 interrupt controller (Status, Cause, EPC)
//
// Purpose: holds Status/Cause/EPC, decides when the core takes an interrupt
// and supplies the ERET return address.
//
// Ports:
//   clock          in   system clock, all state updates on the rising edge
//   reset          in   synchronous active-high reset, clears all state
//   irq_in         in   level-sensitive device interrupt lines (NUM_IRQ)
//   regnum         in   CP0 register number for MFC0/MTC0
//   wr_data        in   MTC0 source data
//   MTC0           in   write enable for the register selected by regnum
//   ERET           in   exception return executing this cycle
//   next_pc        in   word address of the next instruction (PC[31:2])
//   rd_data        out  MFC0 read data (combinational)
//   EPC            out  saved return word address, to the PC mux
//   TakenInterrupt out  redirect fetch to the handler this cycle (combinational)
module cp0_intc
  import cp0_intc_pkg::*;
#(
  parameter int NUM_IRQ   = 8,
  parameter int TIMER_IRQ = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [4:0]         regnum,
  input  logic [31:0]        wr_data,
  input  logic               MTC0,
  input  logic               ERET,
  input  logic [29:0]        next_pc,
  output logic [31:0]        rd_data,
  output logic [29:0]        EPC,
  output logic               TakenInterrupt
);

  // The timer line index only has to be a legal line; the controller treats
  // all lines alike, so it is checked here and otherwise unused.
  if (NUM_IRQ < 1 || NUM_IRQ > 8 || TIMER_IRQ < 0 || TIMER_IRQ >= NUM_IRQ) begin : g_bad_param
    $error("cp0_intc: illegal NUM_IRQ/TIMER_IRQ combination");
  end

  logic [31:0]        user_status;
  logic               exception_level;
  logic [29:0]        epc_q;
  logic [NUM_IRQ-1:0] ip_q;

  logic [NUM_IRQ-1:0] int_mask;
  logic               pending;
  logic               status_wr;
  logic               epc_wr;
  logic [31:0]        status_rd;
  logic [31:0]        cause_rd;
  logic [31:0]        epc_rd;

  assign int_mask  = user_status[IM_LSB +: NUM_IRQ];
  assign pending   = |(ip_q & int_mask);
  assign status_wr = MTC0 && (regnum == STATUS_REG);
  assign epc_wr    = MTC0 && (regnum == EPC_REG);

  // Decision uses the pre-write Status: an MTC0 in the same cycle only
  // affects the following cycles.
  assign TakenInterrupt = pending && user_status[IE_BIT] && !exception_level;

  // EXL is always reported from its own flop; the stored bit 1 is shadowed.
  assign status_rd = {user_status[31:EXL_BIT+1], exception_level, user_status[IE_BIT]};
  assign cause_rd  = 32'(ip_q) << IP_LSB;
  assign epc_rd    = {epc_q, 2'b00};
  assign EPC       = epc_q;

  always_comb begin
    rd_data = 32'h0;
    case (regnum)
      STATUS_REG: rd_data = status_rd;
      CAUSE_REG:  rd_data = cause_rd;
      EPC_REG:    rd_data = epc_rd;
      default:    rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      user_status     <= 32'h0;
      exception_level <= 1'b0;
      epc_q           <= 30'h0;
      ip_q            <= '0;
    end else begin
      // Registering the lines cuts the device-to-PC-mux combinational path.
      ip_q <= irq_in;

      if (status_wr) begin
        user_status <= wr_data;
      end

      if (TakenInterrupt) begin
        exception_level <= 1'b1;
      end else if (ERET) begin
        exception_level <= 1'b0;
      end

      if (TakenInterrupt) begin
        epc_q <= next_pc;
      end else if (epc_wr) begin
        epc_q <= wr_data[31:2];
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// tb/tb_cp0_intc.sv - self-checking bench for cp0_intc with a behavioural model
module tb_cp0_intc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = 8'h00;
  logic [4:0]  regnum = 5'd0;
  logic [31:0] wr_data = 32'h0;
  logic        MTC0 = 1'b0;
  logic        ERET = 1'b0;
  logic [29:0] next_pc = 30'h0;
  logic [31:0] rd_data;
  logic [29:0] EPC;
  logic        TakenInterrupt;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Architectural model state
  logic [31:0] m_status = 32'h0;
  bit          m_exl = 1'b0;
  logic [29:0] m_epc = 30'h0;
  logic [7:0]  m_ip = 8'h0;

  cp0_intc #(.NUM_IRQ(8), .TIMER_IRQ(7)) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .regnum(regnum),
    .wr_data(wr_data), .MTC0(MTC0), .ERET(ERET), .next_pc(next_pc),
    .rd_data(rd_data), .EPC(EPC), .TakenInterrupt(TakenInterrupt)
  );

  always #5 clock = ~clock;

  function automatic bit m_taken();
    return ((m_ip & m_status[15:8]) != 8'h0) && m_status[0] && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd12) return {m_status[31:2], m_exl, m_status[0]};
    if (r == 5'd13) return {16'h0, m_ip, 8'h0};
    if (r == 5'd14) return {m_epc, 2'b00};
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every rising edge from the inputs held during the cycle.
  always @(posedge clock) begin
    bit t;
    if (reset) begin
      m_status = 32'h0;
      m_exl    = 1'b0;
      m_epc    = 30'h0;
      m_ip     = 8'h0;
    end else begin
      t = m_taken();
      if (MTC0 && regnum == 5'd12) m_status = wr_data;
      if (t) begin
        m_exl = 1'b1;
        m_epc = next_pc;
      end else begin
        if (ERET) m_exl = 1'b0;
        if (MTC0 && regnum == 5'd14) m_epc = wr_data[31:2];
      end
      m_ip = irq_in;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clock) begin
    if (run_cmp) begin
      check("cmp_rd_data", rd_data, m_read(regnum));
      check("cmp_epc", {2'b00, EPC}, {2'b00, m_epc});
      check("cmp_taken", {31'h0, TakenInterrupt}, {31'h0, m_taken()});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_check(input string name, input logic [4:0] r, input logic [31:0] exp);
    regnum = r;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    regnum = r; wr_data = d; MTC0 = 1'b1;
    step();
    MTC0 = 1'b0;
  endtask

  initial begin
    // 1: reset state with all lines high
    reset = 1'b1; irq_in = 8'hFF;
    step();
    run_cmp = 1'b1;
    step();
    read_check("t1_status", 5'd12, 32'h0);
    read_check("t1_cause", 5'd13, 32'h0);
    read_check("t1_epc", 5'd14, 32'h0);
    check("t1_taken", {31'h0, TakenInterrupt}, 32'h0);

    // 2: timer interrupt taken one cycle after the line rises
    reset = 1'b0; irq_in = 8'h00;
    step();
    mtc0(5'd12, 32'h0000_8001);
    irq_in = 8'h80; next_pc = 30'h00100010;
    #1;
    check("t2_taken_early", {31'h0, TakenInterrupt}, 32'h0);
    step();
    check("t2_taken", {31'h0, TakenInterrupt}, 32'h1);
    step();
    read_check("t2_epc_rd", 5'd14, 32'h0040_0040);
    check("t2_epc_port", {2'b00, EPC}, 32'h0010_0010);
    read_check("t2_status", 5'd12, 32'h0000_8003);
    check("t2_taken_exl", {31'h0, TakenInterrupt}, 32'h0);

    // 3: ERET leaves the handler
    irq_in = 8'h00; ERET = 1'b1;
    step();
    ERET = 1'b0;
    read_check("t3_status", 5'd12, 32'h0000_8001);
    check("t3_taken", {31'h0, TakenInterrupt}, 32'h0);
    step();
    check("t3_taken2", {31'h0, TakenInterrupt}, 32'h0);

    // 4: masked lines never interrupt
    irq_in = 8'hFF;
    mtc0(5'd12, 32'h0000_0001);
    step();
    check("t4_taken", {31'h0, TakenInterrupt}, 32'h0);
    read_check("t4_cause", 5'd13, 32'h0000_FF00);

    // 5: EPC write, Cause write ignored, unmapped register reads zero
    mtc0(5'd14, 32'h1234_5677);
    read_check("t5_epc", 5'd14, 32'h1234_5674);
    mtc0(5'd13, 32'hFFFF_FFFF);
    read_check("t5_cause", 5'd13, 32'h0000_FF00);
    read_check("t5_other", 5'd9, 32'h0);

    // 6: reset in the middle of a handler
    mtc0(5'd12, 32'h0000_8001);
    check("t6_taken", {31'h0, TakenInterrupt}, 32'h1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    read_check("t6_status", 5'd12, 32'h0);
    read_check("t6_cause", 5'd13, 32'h0);
    read_check("t6_epc", 5'd14, 32'h0);
    check("t6_taken0", {31'h0, TakenInterrupt}, 32'h0);
    step();
    check("t6_taken1", {31'h0, TakenInterrupt}, 32'h0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      irq_in  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      case ($urandom_range(0, 4))
        0: regnum = 5'd12;
        1: regnum = 5'd13;
        2: regnum = 5'd14;
        3: regnum = 5'd12;
        default: regnum = 5'($urandom);
      endcase
      MTC0    = ($urandom_range(0, 3) == 0);
      wr_data = $urandom;
      ERET    = ($urandom_range(0, 5) == 0);
      next_pc = 30'($urandom);
      step();
    end
    reset = 1'b0; MTC0 = 1'b0; ERET = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
